// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo write arbiter.
// The ID width helper keeps the width at 1 bit or more.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  function automatic int arb_id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_rr_write_arbiter_rr_pick.sv
// Round-robin pick: first valid request after last_grant.
// Indices wrap modulo NUM_REQ, so any count of requesters works.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = arb_id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] last_grant,
  output logic [ID_WIDTH-1:0] winner,
  output logic                any_valid
);

  int idx;

  // Scan from farthest to nearest so the nearest valid one wins.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (req[idx]) begin
        winner    = ID_WIDTH'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin arbiter sharing one fifo write port.
// Optional packet locking; registered output beat tagged by source.
module fifo_rr_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int ID_WIDTH    = arb_id_width(NUM_REQ),
  parameter int PACKET_MODE = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data,
  input  logic [NUM_REQ-1:0]                  req_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic [ID_WIDTH-1:0]                 out_src,
  output logic                                out_last,
  output logic                                locked
);

  if (NUM_REQ < 2) begin : g_bad_num_req
    $fatal(1, "fifo_rr_write_arbiter: NUM_REQ must be >= 2");
  end

  arb_state_e          state;
  arb_state_e          state_d;
  logic [ID_WIDTH-1:0] last_grant;
  logic [ID_WIDTH-1:0] lock_id;
  logic [ID_WIDTH-1:0] winner;
  logic [ID_WIDTH-1:0] grant_id;
  logic                any_valid;
  logic                grant_en;
  logic                can_load;
  logic                accept;

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .winner     (winner),
    .any_valid  (any_valid)
  );

  // Grant select; a locked channel is granted without looking at its valid.
  always_comb begin
    can_load = !out_valid || out_ready;
    grant_id = winner;
    grant_en = any_valid;
    if (state == ARB_LOCKED) begin
      grant_id = lock_id;
      grant_en = 1'b1;
    end
    req_ready = '0;
    if (rst_n && grant_en && can_load) begin
      req_ready[grant_id] = 1'b1;
    end
    accept = req_valid[grant_id] && req_ready[grant_id];
  end

  // Next state: lock on a non-last beat, unlock on the last beat.
  always_comb begin
    state_d = state;
    unique case (state)
      ARB_IDLE: begin
        if (accept && PACKET_MODE != 0 && !req_last[grant_id]) begin
          state_d = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (accept && req_last[grant_id]) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State, lock owner and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      lock_id    <= '0;
      last_grant <= ID_WIDTH'(NUM_REQ - 1);
    end else begin
      state <= state_d;
      if (accept) begin
        last_grant <= grant_id;
        lock_id    <= grant_id;
      end
    end
  end

  // Output beat register; cleared whenever it empties.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= req_data[grant_id];
      out_src   <= grant_id;
      out_last  <= req_last[grant_id];
    end else if (can_load) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      out_last  <= 1'b0;
    end
  end

  assign locked = (state == ARB_LOCKED);

  a_ready_onehot: assert property (
    @(posedge clk) $onehot0(req_ready));

  a_out_hold: assert property (
    @(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=>
      (out_valid && $stable(out_data) &&
       $stable(out_src) && $stable(out_last)));

endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// Directed bench for fifo_rr_write_arbiter (4 channels, packet mode).
// Inputs driven after the rising edge; outputs checked mid-cycle.
module tb_fifo_rr_write_arbiter;

  logic             clk;
  logic             rst_n;
  logic [3:0]       req_valid;
  logic [3:0]       req_ready;
  logic [3:0][7:0]  req_data;
  logic [3:0]       req_last;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic [1:0]       out_src;
  logic             out_last;
  logic             locked;

  int errors = 0;
  int checks = 0;

  fifo_rr_write_arbiter #(
    .NUM_REQ     (4),
    .DATA_WIDTH  (8),
    .PACKET_MODE (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_last  (req_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_last  (out_last),
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v,
                         input logic [1:0] s, input logic [7:0] d,
                         input logic l, input logic lk);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_src"}, 32'(out_src), 32'(s));
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_last"}, 32'(out_last), 32'(l));
    chk({tag, "_locked"}, 32'(locked), 32'(lk));
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l);
    req_valid = v;
    req_last  = l;
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    req_valid = 4'hF;
    req_last  = 4'hF;
    for (int i = 0; i < 4; i++) req_data[i] = 8'(8'h10 + i);

    // Reset state, ready forced low while in reset
    tick;
    tick;
    settle;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk_out("rst", 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);

    // All valid, single-beat packets: 0,1,2,3,0
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle;
      chk("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
      tick;
      if (k == 4) drive(4'b0000, 4'b0000);
      chk_out("rr", 1'b1, 2'(k % 4), 8'(8'h10 + k % 4), 1'b1, 1'b0);
    end
    tick;
    chk("rr_drain", 32'(out_valid), 32'h0);

    // Three-beat packet on ch1, ch2 waiting
    req_data[1] = 8'hA1;
    req_data[2] = 8'hB2;
    drive(4'b0110, 4'b0100);
    settle;
    chk("pkt_r1", 32'(req_ready), 32'b0010);
    tick;
    chk_out("pkt1", 1'b1, 2'd1, 8'hA1, 1'b0, 1'b1);
    req_data[1] = 8'hA2;
    settle;
    chk("pkt_r2", 32'(req_ready), 32'b0010);
    tick;
    chk_out("pkt2", 1'b1, 2'd1, 8'hA2, 1'b0, 1'b1);
    req_data[1] = 8'hA3;
    drive(4'b0110, 4'b0110);
    settle;
    chk("pkt_r3", 32'(req_ready), 32'b0010);
    tick;
    chk_out("pkt3", 1'b1, 2'd1, 8'hA3, 1'b1, 1'b0);
    drive(4'b0100, 4'b0100);
    settle;
    chk("pkt_r4", 32'(req_ready), 32'b0100);
    tick;
    chk_out("pkt_ch2", 1'b1, 2'd2, 8'hB2, 1'b1, 1'b0);
    drive(4'b0000, 4'b0000);
    tick;
    chk("pkt_drain", 32'(out_valid), 32'h0);

    // Fifo full for 5 cycles holding 0x55
    req_data[0] = 8'h55;
    drive(4'b0001, 4'b0001);
    settle;
    chk("full_r0", 32'(req_ready), 32'b0001);
    tick;
    out_ready   = 1'b0;
    req_data[3] = 8'h66;
    drive(4'b1000, 4'b1000);
    for (int i = 0; i < 5; i++) begin
      settle;
      chk("full_ready", 32'(req_ready), 32'h0);
      chk_out("full", 1'b1, 2'd0, 8'h55, 1'b1, 1'b0);
      tick;
    end
    out_ready = 1'b1;
    settle;
    chk("full_rel", 32'(req_ready), 32'b1000);
    chk_out("full_end", 1'b1, 2'd0, 8'h55, 1'b1, 1'b0);
    tick;
    chk_out("full_next", 1'b1, 2'd3, 8'h66, 1'b1, 1'b0);
    drive(4'b0000, 4'b0000);
    tick;
    chk("full_drain", 32'(out_valid), 32'h0);

    // Locked ch3 drops valid for 2 cycles, ch0 waiting
    req_data[3] = 8'hC1;
    drive(4'b1000, 4'b0000);
    settle;
    chk("lk_r0", 32'(req_ready), 32'b1000);
    tick;
    chk_out("lk1", 1'b1, 2'd3, 8'hC1, 1'b0, 1'b1);
    req_data[0] = 8'h0D;
    drive(4'b0001, 4'b0001);
    settle;
    chk("lk_gap1", 32'(req_ready), 32'b1000);
    tick;
    chk_out("bub1", 1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
    settle;
    chk("lk_gap2", 32'(req_ready), 32'b1000);
    tick;
    chk_out("bub2", 1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
    req_data[3] = 8'hC2;
    drive(4'b1001, 4'b1001);
    settle;
    chk("lk_r3", 32'(req_ready), 32'b1000);
    tick;
    chk_out("lk2", 1'b1, 2'd3, 8'hC2, 1'b1, 1'b0);
    drive(4'b0001, 4'b0001);
    settle;
    chk("lk_r4", 32'(req_ready), 32'b0001);
    tick;
    chk_out("lk_ch0", 1'b1, 2'd0, 8'h0D, 1'b1, 1'b0);
    drive(4'b0000, 4'b0000);
    tick;

    // Wrap: last_grant=3, only ch2 valid, then ch2+ch3
    req_data[3] = 8'h33;
    drive(4'b1000, 4'b1000);
    tick;
    chk_out("wrap_pre", 1'b1, 2'd3, 8'h33, 1'b1, 1'b0);
    req_data[2] = 8'h22;
    drive(4'b0100, 4'b0100);
    settle;
    chk("wrap_r", 32'(req_ready), 32'b0100);
    tick;
    chk_out("wrap", 1'b1, 2'd2, 8'h22, 1'b1, 1'b0);
    drive(4'b1100, 4'b1100);
    settle;
    chk("wrap_r2", 32'(req_ready), 32'b1000);
    tick;
    chk_out("wrap2", 1'b1, 2'd3, 8'h33, 1'b1, 1'b0);
    drive(4'b0000, 4'b0000);
    tick;

    // Reset while locked on ch1 with a pending beat
    req_data[1] = 8'hE1;
    drive(4'b0010, 4'b0000);
    tick;
    chk_out("pre_rst", 1'b1, 2'd1, 8'hE1, 1'b0, 1'b1);
    rst_n = 1'b0;
    drive(4'b1111, 4'b1111);
    settle;
    chk("rst_force", 32'(req_ready), 32'h0);
    tick;
    chk_out("mid_rst", 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    settle;
    chk("post_rst_r", 32'(req_ready), 32'b0001);
    tick;
    chk_out("post_rst", 1'b1, 2'd0, 8'h0D, 1'b1, 1'b0);
    drive(4'b0000, 4'b0000);
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_rr_write_arbiter.md
Name: fifo_rr_write_arbiter

Overview:
Shares the single write port of a fifo instance between NUM_REQ producers using round-robin arbitration with optional packet locking. A registered output stage drives the fifo's write_valid/write_ready/data_in directly. Back-pressure from fifo full propagates to the granted producer only. Each output beat is tagged with the source index.

Parameters:
NUM_REQ, 4, number of producer channels (>=2)
DATA_WIDTH, 8, payload width, matches fifo DATA_WIDTH
ID_WIDTH, $clog2(NUM_REQ), width of source index
PACKET_MODE, 1, 1 = hold grant until req_last beat accepted; 0 = re-arbitrate every beat

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
req_valid  input  NUM_REQ  per-producer beat valid
req_ready  output  NUM_REQ  per-producer beat accepted, one-hot or zero
req_data  input  NUM_REQ x DATA_WIDTH  per-producer payload
req_last  input  NUM_REQ  final beat of producer packet
out_valid  output  1  to fifo write_valid
out_ready  input  1  from fifo write_ready
out_data  output  DATA_WIDTH  to fifo data_in; '0 whenever out_valid=0
out_src  output  ID_WIDTH  source index of current out beat
out_last  output  1  req_last of current out beat
locked  output  1  high while in LOCKED state

Behaviour:
- Reset (rst_n low at posedge): out_valid=0, out_data='0, out_src=0, out_last=0, state=IDLE, last_grant=NUM_REQ-1 (so requester 0 has top priority first), locked=0. req_ready is forced 0 combinationally while rst_n=0.
- Output stage: single register. can_load = !out_valid || out_ready. Beat from producer g is accepted when req_valid[g] && req_ready[g]. It loads out_* on the next edge. Latency is 1 cycle from acceptance to out_valid. With out_ready=1 continuously, throughput is 1 beat/cycle with no bubbles.
- If out_valid && !out_ready, out_* hold stable and all req_ready=0.
- FSM states: IDLE and LOCKED(id).
- IDLE:
  - winner = first i with req_valid[i], searching from last_grant+1 upward, modulo NUM_REQ.
  - req_ready[winner] = can_load; all other bits are 0.
  - If no valid requester, req_ready=0.
  - On acceptance, last_grant<=winner.
  - If PACKET_MODE=1 and req_last[winner]=0, go to LOCKED(winner). Otherwise stay in IDLE.
- LOCKED(id):
  - req_ready[id] = can_load; all other bits are 0, regardless of their valid.
  - Accepting a beat with req_last=1 returns to IDLE. The next arbitration starts from id+1.
  - If req_valid[id] drops, stay LOCKED and insert bubbles. There is no timeout.
- Grant is never given to a channel whose req_valid=0. req_ready must not depend on req_valid of a locked channel (no combinational loop through id).
- A single-beat packet (req_last=1 on its first beat) never enters LOCKED.
- When PACKET_MODE=0, req_last is passed through to out_last but ignored by the FSM. locked stays 0.
- Wrap-around: the search after last_grant=NUM_REQ-1 starts at index 0.
- Reset mid-packet: the lock and any pending output beat are discarded. No partial-beat recovery is provided; packet integrity after reset is the producer's responsibility.
- Non-power-of-2 NUM_REQ is legal. Modulo is applied on index, not by bit truncation.
- Simulation-only checks:
  - $onehot0(req_ready) every cycle.
  - out_* stable while out_valid && !out_ready.
  - $fatal if NUM_REQ<2.

Decomposition:
- Package fifo_arb_pkg: arb_state_e enum {ARB_IDLE, ARB_LOCKED}, and a localparam helper for ID width.
- Sub-module rr_pick: purely combinational. Inputs are req vector and last_grant. Outputs are winner index and any_valid. It is instantiated once and reused by future read-side schedulers.

Test Plan:
- All 4 channels valid, single-beat packets, out_ready=1 → grants in order 0,1,2,3,0; out_src sequence 0,1,2,3,0 starting 1 cycle after release from reset.
- Ch1 sends 3-beat packet (0xA1,0xA2,0xA3 last), ch2 valid throughout → out_data A1,A2,A3 contiguous with src=1; ch2 beat appears only after A3; locked high for 2 cycles.
- Fifo full: out_ready=0 for 5 cycles with out_valid=1, data 0x55 → out_data holds 0x55, req_ready=0 for those 5 cycles. Beat completes on the first cycle out_ready=1, with no lost or duplicated beats.
- Locked ch3 drops valid for 2 cycles mid-packet while ch0 is valid → ch0 never granted; 2 bubbles appear on out_valid; the packet then completes and ch0 is granted next.
- Only ch2 valid, last_grant=3 → wrap search grants ch2; last_grant becomes 2; the next concurrent ch2+ch3 request grants ch3.
- Reset asserted while LOCKED on ch1 with out_valid=1 → next cycle out_valid=0, out_data=0, locked=0; first grant after reset goes to ch0 when all channels are valid.
